// File: rtl/adder_scheduler.sv
// Purpose: round-robin sequencer sharing one 4-bit adder between two 16-bit add requesters.
// Latency: accept at t, nibbles added t+1..t+WIDTH/4, result strobe the cycle after (t+5 for 16 bits).
// Backpressure: one operation in flight; Req_Ready only pulses in IDLE with En high; En low freezes everything.
module adder_scheduler #(
    parameter int WIDTH = 16,
    parameter int NIB   = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             En,
    input  logic [1:0]       Req_Valid,
    input  logic [WIDTH-1:0] Req_A0,
    input  logic [WIDTH-1:0] Req_B0,
    input  logic             Req_Cin0,
    input  logic [WIDTH-1:0] Req_A1,
    input  logic [WIDTH-1:0] Req_B1,
    input  logic             Req_Cin1,
    output logic [1:0]       Req_Ready,
    output logic [NIB-1:0]   Adder_A,
    output logic [NIB-1:0]   Adder_B,
    output logic             Adder_Cin,
    input  logic [NIB-1:0]   Adder_Sum,
    input  logic             Adder_Cout,
    output logic             Res_Valid,
    output logic [WIDTH-1:0] Res_Sum,
    output logic             Res_Cout,
    output logic             Res_Ovf,
    output logic             Res_Id,
    output logic             Busy
);

    localparam int NN = WIDTH / NIB;
    localparam int CW = (NN > 1) ? $clog2(NN) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             own_q, own_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] res_sum_q, res_sum_d;
    logic             res_cout_q, res_cout_d;
    logic             res_ovf_q, res_ovf_d;
    logic             res_id_q, res_id_d;

    logic             win;
    logic [WIDTH-1:0] sum_next;

    // Next-state, arbitration, adder drive and result assembly
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        own_d      = own_q;
        last_d     = last_q;
        res_sum_d  = res_sum_q;
        res_cout_d = res_cout_q;
        res_ovf_d  = res_ovf_q;
        res_id_d   = res_id_q;
        Req_Ready  = 2'b00;
        Res_Valid  = 1'b0;
        Adder_A    = '0;
        Adder_B    = '0;
        Adder_Cin  = 1'b0;
        sum_next   = shadow_q;

        // On a tie the requester not served last wins; otherwise the lone requester wins.
        win = (Req_Valid == 2'b11) ? ~last_q : Req_Valid[1];

        unique case (state_q)
            ST_IDLE: begin
                if (En && (|Req_Valid)) begin
                    Req_Ready = win ? 2'b10 : 2'b01;
                    a_d       = win ? Req_A1 : Req_A0;
                    b_d       = win ? Req_B1 : Req_B0;
                    carry_d   = win ? Req_Cin1 : Req_Cin0;
                    cnt_d     = '0;
                    own_d     = win;
                    last_d    = win;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                Adder_A   = a_q[int'(cnt_q) * NIB +: NIB];
                Adder_B   = b_q[int'(cnt_q) * NIB +: NIB];
                Adder_Cin = carry_q;
                sum_next[int'(cnt_q) * NIB +: NIB] = Adder_Sum;
                if (En) begin
                    shadow_d = sum_next;
                    carry_d  = Adder_Cout;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(NN - 1)) begin
                        // Publish the finished result so it is stable for the whole DONE cycle.
                        res_sum_d  = sum_next;
                        res_cout_d = Adder_Cout;
                        res_ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                     (sum_next[WIDTH-1] != a_q[WIDTH-1]);
                        res_id_d   = own_q;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (En) begin
                    Res_Valid = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any operation in flight
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            shadow_q   <= '0;
            own_q      <= 1'b0;
            last_q     <= 1'b1;
            res_sum_q  <= '0;
            res_cout_q <= 1'b0;
            res_ovf_q  <= 1'b0;
            res_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            own_q      <= own_d;
            last_q     <= last_d;
            res_sum_q  <= res_sum_d;
            res_cout_q <= res_cout_d;
            res_ovf_q  <= res_ovf_d;
            res_id_q   <= res_id_d;
        end
    end

    assign Res_Sum  = res_sum_q;
    assign Res_Cout = res_cout_q;
    assign Res_Ovf  = res_ovf_q;
    assign Res_Id   = res_id_q;
    assign Busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adder_scheduler.sv
// Purpose: randomized and directed bench for adder_scheduler with a scoreboard of expected results.
// Latency: reference model counts enabled cycles from accept (4 nibble cycles, then the result strobe).
// Backpressure: requesters hold valid/operands until they see their ready pulse; En is toggled randomly.
module tb_adder_scheduler;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
    } op_t;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        id;
    } res_t;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        En;
    logic [1:0]  v;
    logic [15:0] ra [2];
    logic [15:0] rb [2];
    logic        rc [2];
    logic [1:0]  Req_Ready;
    logic [3:0]  Adder_A, Adder_B, Adder_Sum;
    logic        Adder_Cin, Adder_Cout;
    logic        Res_Valid, Res_Cout, Res_Ovf, Res_Id, Busy;
    logic [15:0] Res_Sum;

    always #5 Clk = ~Clk;

    // The shared 4-bit adder
    assign {Adder_Cout, Adder_Sum} = {1'b0, Adder_A} + {1'b0, Adder_B} + {4'b0000, Adder_Cin};

    adder_scheduler #(.WIDTH(16), .NIB(4)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .En         (En),
        .Req_Valid  (v),
        .Req_A0     (ra[0]),
        .Req_B0     (rb[0]),
        .Req_Cin0   (rc[0]),
        .Req_A1     (ra[1]),
        .Req_B1     (rb[1]),
        .Req_Cin1   (rc[1]),
        .Req_Ready  (Req_Ready),
        .Adder_A    (Adder_A),
        .Adder_B    (Adder_B),
        .Adder_Cin  (Adder_Cin),
        .Adder_Sum  (Adder_Sum),
        .Adder_Cout (Adder_Cout),
        .Res_Valid  (Res_Valid),
        .Res_Sum    (Res_Sum),
        .Res_Cout   (Res_Cout),
        .Res_Ovf    (Res_Ovf),
        .Res_Id     (Res_Id),
        .Busy       (Busy)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    op_t  opq0[$];
    op_t  opq1[$];
    res_t exp_q[$];
    int   grant_log[$];

    // Reference model state
    int         ph = 0;
    logic       last = 1'b1;
    op_t        cur = '0;
    logic       cur_id = 1'b0;
    res_t       hold = '0;
    logic [1:0] m_er;
    int         m_w, m_k;
    logic [8:0] m_adr;
    res_t       mon_e;
    logic [1:0] seen;

    always @(posedge Clk) cyc++;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic res_t ref_add(input op_t o, input logic id);
        res_t        r;
        logic [16:0] s;
        s      = {1'b0, o.a} + {1'b0, o.b} + {16'd0, o.cin};
        r.sum  = s[15:0];
        r.cout = s[16];
        r.ovf  = (o.a[15] == o.b[15]) && (s[15] != o.a[15]);
        r.id   = id;
        return r;
    endfunction

    // Carry into bit 4k of a true 16-bit add
    function automatic logic ref_cin(input op_t o, input int k);
        logic [16:0] m;
        logic [16:0] low;
        m   = (17'd1 << (4 * k)) - 17'd1;
        low = ({1'b0, o.a} & m) + ({1'b0, o.b} & m) + {16'd0, o.cin};
        return low[4 * k];
    endfunction

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 5))
            0: return 16'hFFFF;
            1: return 16'h7FFF;
            2: return 16'h8000;
            3: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.a   = pick16();
        o.b   = pick16();
        o.cin = 1'($urandom_range(0, 1));
        return o;
    endfunction

    // Reference model: cycle-level expectations counted from acceptance
    always @(negedge Clk) begin
        if (!Rst_n) begin
            ph   = 0;
            last = 1'b1;
            hold = '0;
            exp_q.delete();
            chk("reset_ready", 32'(Req_Ready), 32'd0);
            chk("reset_valid", 32'(Res_Valid), 32'd0);
            chk("reset_busy", 32'(Busy), 32'd0);
        end else begin
            m_er = 2'b00;
            m_w  = 0;
            if (ph == 0 && En && v != 2'b00) begin
                m_w  = (v == 2'b11) ? (last ? 0 : 1) : (v[1] ? 1 : 0);
                m_er = (m_w == 1) ? 2'b10 : 2'b01;
            end
            chk("req_ready", 32'(Req_Ready), 32'(m_er));
            chk("res_valid", 32'(Res_Valid), 32'(ph == 5 && En));
            chk("busy", 32'(Busy), 32'(ph != 0));
            chk("res_hold", 32'({Res_Sum, Res_Cout, Res_Ovf, Res_Id}), 32'(hold));
            m_adr = '0;
            if (ph >= 1 && ph <= 4) begin
                m_k   = ph - 1;
                m_adr = {cur.a[4 * m_k +: 4], cur.b[4 * m_k +: 4], ref_cin(cur, m_k)};
            end
            chk("adder_drive", 32'({Adder_A, Adder_B, Adder_Cin}), 32'(m_adr));
            if (En) begin
                if (m_er != 2'b00) begin
                    cur.a  = ra[m_w];
                    cur.b  = rb[m_w];
                    cur.cin = rc[m_w];
                    cur_id = (m_w == 1);
                    exp_q.push_back(ref_add(cur, cur_id));
                    grant_log.push_back(m_w);
                    last = cur_id;
                    ph   = 1;
                end else if (ph >= 1 && ph <= 3) begin
                    ph = ph + 1;
                end else if (ph == 4) begin
                    hold = ref_add(cur, cur_id);
                    ph   = 5;
                end else if (ph == 5) begin
                    ph = 0;
                end
            end
        end
    end

    // Scoreboard monitor: every result strobe pops one expected result
    always @(negedge Clk) begin
        if (Rst_n && Res_Valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(Res_Sum), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("scoreboard", 32'({Res_Sum, Res_Cout, Res_Ovf, Res_Id}), 32'(mon_e));
            end
        end
    end

    // Requester driver: hold request until ready seen, then scramble operands and take the next op
    initial begin
        op_t o;
        seen = 2'b00;
        forever begin
            @(negedge Clk);
            seen = Req_Ready;
            @(posedge Clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (v[i] && seen[i]) begin
                    v[i]  = 1'b0;
                    ra[i] = 16'($urandom);
                    rb[i] = 16'($urandom);
                    rc[i] = 1'($urandom_range(0, 1));
                end
                if (!v[i]) begin
                    if (i == 0 && opq0.size() > 0) begin
                        o = opq0.pop_front();
                        ra[0] = o.a; rb[0] = o.b; rc[0] = o.cin; v[0] = 1'b1;
                    end else if (i == 1 && opq1.size() > 0) begin
                        o = opq1.pop_front();
                        ra[1] = o.a; rb[1] = o.b; rc[1] = o.cin; v[1] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(Req_Ready), 32'd0);
        chk({tag, "_valid"}, 32'(Res_Valid), 32'd0);
        chk({tag, "_res"}, 32'({Res_Sum, Res_Cout, Res_Ovf, Res_Id}), 32'd0);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_adder"}, 32'({Adder_A, Adder_B, Adder_Cin}), 32'd0);
    endtask

    task automatic wait_ready(input int i, output int t);
        int n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!Req_Ready[i] && n < 60);
        chk("ready_timeout", 32'(n >= 60 && !Req_Ready[i]), 32'd0);
        t = cyc;
    endtask

    task automatic wait_result(output int t);
        int n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!Res_Valid && n < 60);
        chk("result_timeout", 32'(!Res_Valid), 32'd0);
        t = cyc;
    endtask

    task automatic drain();
        int n = 0;
        while ((opq0.size() > 0 || opq1.size() > 0 || v != 2'b00 || ph != 0) && n < 3000) begin
            @(negedge Clk);
            n++;
        end
        chk("drain_timeout", 32'(n >= 3000), 32'd0);
        repeat (2) @(negedge Clk);
    endtask

    task automatic run_one(input int i, input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input logic [15:0] es, input logic ec, input logic eo);
        op_t o;
        int  t0, t1;
        o.a = a; o.b = b; o.cin = cin;
        if (i == 0) opq0.push_back(o); else opq1.push_back(o);
        wait_ready(i, t0);
        wait_result(t1);
        chk("dir_latency", 32'(t1 - t0), 32'd5);
        chk("dir_sum", 32'(Res_Sum), 32'(es));
        chk("dir_cout_ovf_id", 32'({Res_Cout, Res_Ovf, Res_Id}), 32'({ec, eo, i[0]}));
        drain();
    endtask

    initial begin
        int t0, t1;
        Rst_n = 1'b0;
        En    = 1'b1;
        v     = 2'b00;
        for (int i = 0; i < 2; i++) begin
            ra[i] = '0; rb[i] = '0; rc[i] = 1'b0;
        end
        #2;
        check_reset_outputs("por");
        repeat (2) @(posedge Clk);
        #2 Rst_n = 1'b1;

        // Directed arithmetic cases
        run_one(0, 16'h1234, 16'h0FCD, 1'b1, 16'h2202, 1'b0, 1'b0);
        run_one(0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_one(1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_one(0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // En stall during nibble 2 with a competing request pending
        opq0.push_back(rand_op());
        wait_ready(0, t0);
        repeat (3) @(posedge Clk);
        #2 En = 1'b0;
        opq1.push_back(rand_op());
        repeat (3) @(posedge Clk);
        #2 En = 1'b1;
        wait_result(t1);
        chk("stall_latency", 32'(t1 - t0), 32'd8);
        drain();

        // Reset during nibble 1
        opq0.push_back(rand_op());
        wait_ready(0, t0);
        repeat (2) @(posedge Clk);
        #2 Rst_n = 1'b0;
        #1 check_reset_outputs("midrun");
        repeat (2) @(posedge Clk);
        #2 Rst_n = 1'b1;

        // Both requesters continuously valid: alternate starting with 0
        grant_log.delete();
        for (int k = 0; k < 4; k++) begin
            opq0.push_back(rand_op());
            opq1.push_back(rand_op());
        end
        drain();
        chk("rr_count", 32'(grant_log.size()), 32'd8);
        for (int k = 0; k < grant_log.size(); k++) chk("rr_order", 32'(grant_log[k]), 32'(k % 2));

        // Random traffic with random enable gaps
        for (int c = 0; c < 500; c++) begin
            @(posedge Clk);
            #2;
            En = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 0) opq0.push_back(rand_op());
                else opq1.push_back(rand_op());
            end
        end
        En = 1'b1;
        drain();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_scheduler.md
# adder_scheduler

Sequencer and round-robin arbiter that shares the team's single 4-bit combinational adder between two requesters, each issuing 16-bit add operations. Operands are captured on a valid/ready handshake and driven through the adder one nibble per cycle, least significant first, with the carry rippled through a register between nibbles. Sum, carry-out, signed overflow and requester ID are reported with a one-cycle result strobe. The block sits between the requesting datapath units and the shared `adder` instance.

## Interface
Parameters:
- `WIDTH`, 16: operand width; must be a multiple of 4.
- `NIB`, 4: adder slice width; fixed at 4.

Ports:
- `Clk` in 1: single clock, rising edge.
- `Rst_n` in 1: reset, asynchronous, active-low.
- `En` in 1: global enable. Low freezes all state and blocks acceptance.
- `Req_Valid` in 2: bit i is high while requester i presents an operation.
- `Req_A0`, `Req_B0` in WIDTH: requester 0 operands.
- `Req_Cin0` in 1: requester 0 carry-in.
- `Req_A1`, `Req_B1` in WIDTH: requester 1 operands.
- `Req_Cin1` in 1: requester 1 carry-in.
- `Req_Ready` out 2: one-cycle accept pulse for requester i.
- `Adder_A`, `Adder_B` out 4: nibble operands driven to the shared adder.
- `Adder_Cin` out 1: carry into the current nibble.
- `Adder_Sum` in 4: adder sum, combinational.
- `Adder_Cout` in 1: adder carry-out, combinational.
- `Res_Valid` out 1: one-cycle result strobe.
- `Res_Sum` out WIDTH: result sum.
- `Res_Cout` out 1: carry out of bit WIDTH-1.
- `Res_Ovf` out 1: two's-complement overflow.
- `Res_Id` out 1: requester that owns the result.
- `Busy` out 1: high when the state is not IDLE.

## Operation
- State machine: IDLE -> RUN -> DONE -> IDLE.
- **IDLE:**
  - If `En`=1 and any `Req_Valid` bit is set, grant one requester: raise its `Req_Ready` for that cycle.
  - Latch that requester's A, B and Cin. Load the carry register with Cin and clear the nibble counter.
  - Go to RUN.
- **Arbitration:** round-robin with a last-grant pointer.
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins.
  - After reset the pointer is set so that requester 0 wins the first tie.
  - The pointer updates only on a grant.
- **RUN:**
  - Drive `Adder_A`/`Adder_B` = latched nibble k and `Adder_Cin` = carry register.
  - Each enabled cycle: write `Adder_Sum` into result nibble k, load the carry register with `Adder_Cout`, and increment k.
  - After nibble WIDTH/4-1, go to DONE.
- **DONE:**
  - `Res_Valid`=1 for exactly one cycle.
  - `Res_Cout` = final carry.
  - `Res_Ovf` = (A[MSB]==B[MSB]) && (Sum[MSB]!=A[MSB]).
  - `Res_Id` = granted requester.
  - Go to IDLE.
- **`Res_Sum`, `Res_Cout`, `Res_Ovf`, `Res_Id`:** hold their values until the next DONE. They are registered and do not change during a new operation's RUN; results are assembled in an internal shadow register.
- **Requester rules:**
  - A requester keeps `Req_Valid` and its operands stable until it sees `Req_Ready`.
  - Operand changes after acceptance have no effect.
  - Dropping `Req_Valid` before acceptance withdraws the request; no error is flagged.
- **`En`=0:** FSM, counter, carry, pointer and outputs hold. `Req_Ready` and `Res_Valid` are forced to 0. A `Res_Valid` due in a cycle with `En` low is issued in the first cycle `En` returns high.
- **When not in RUN:** `Adder_A`, `Adder_B`, `Adder_Cin` = 0.
- **Arithmetic:** modulo 2^WIDTH. The carry rippled across nibbles equals the carry of a true 16-bit add.

## Timing
- **Reset values:** state IDLE, `Req_Ready`=0, `Res_Valid`=0, `Res_Sum`=0, `Res_Cout`=0, `Res_Ovf`=0, `Res_Id`=0, `Busy`=0, adder outputs 0, pointer favouring requester 0.
- **Latency and throughput:**
  - Accept in cycle t (`Req_Ready`=1).
  - RUN occupies t+1..t+4.
  - `Res_Valid` in t+5, with `En` held high.
  - Next accept no earlier than t+6, giving one operation per 6 cycles.
- `Busy`=1 from t+1 through t+5.
- **Reset mid-operation:** on `Rst_n` assertion the operation is discarded immediately. No `Res_Valid` is produced. The requester is considered served, since `Req_Ready` was already given.
- **Simultaneous new request and DONE:** no acceptance occurs in the DONE cycle; the request waits for IDLE.

## Test plan
1. **Single add, requester 0:** A=0x1234, B=0x0FCD, Cin=1 -> `Req_Ready[0]` at t; `Res_Valid` at t+5 with Sum=0x2202, Cout=0, Ovf=0, Id=0.
2. **Carry chain and unsigned wrap:** A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1, Ovf=0; each RUN cycle shows `Adder_Cin`=1 for nibbles 1-3.
3. **Signed overflow:** A=0x7FFF, B=0x0001 -> Sum=0x8000, Cout=0, Ovf=1. A=0x8000, B=0x8000 -> Sum=0x0000, Cout=1, Ovf=1.
4. **Round-robin:** both requesters valid continuously from reset -> grant order 0,1,0,1. `Res_Id` alternates and accepts are spaced 6 cycles apart.
5. **`En` stall:** drop `En` for 3 cycles during RUN nibble 2 -> result still correct, `Res_Valid` delayed by exactly 3 cycles, no spurious `Req_Ready`.
6. **Reset mid-RUN:** assert `Rst_n`=0 at nibble 1 -> all outputs return to reset values asynchronously, no `Res_Valid`; the next request after release is granted to requester 0 on a tie.
